ticket_vend_ctrl: RTL and testbench
===================================

# ticket_vend_ctrl

Transaction controller for the automatic ticket machine. It takes ticket selections and coin-insert events, runs the sale state machine and dispenses tickets as pulses. It produces the `money`, `ticketType`, `ticketCount` and `moneyReturn` values that `money_scan` consumes, so it is the producing end of the `money_scan` display interface.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000: number of inactivity cycles in PAY before an automatic cancel. Used only when `TICKET_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel_vld` in 1: one-cycle selection strobe.
- `sel_type` in 3: ticket type; values 0–3 are valid.
- `sel_count` in 3: ticket count; values 1–7 are valid.
- `coin_vld` in 1: one-cycle coin strobe.
- `coin_val` in 2: coin code; 0→1, 1→5, 2→10, 3→20 yuan.
- `cancel` in 1: one-cycle cancel strobe.
- `money` out 8: total paid in the current transaction.
- `ticketType` out 3: latched ticket type.
- `ticketCount` out 3: latched ticket count.
- `moneyReturn` out 8: change or refund amount.
- `ticket_out` out 1: one pulse per dispensed ticket.
- `change_vld` out 1: one-cycle strobe; `moneyReturn` is valid in this cycle.
- `sel_err` out 1: one-cycle strobe on a rejected selection.
- `coin_reject` out 1: one-cycle strobe on a rejected coin.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Reset values: every output is 0 and the state is IDLE. Reset mid-transaction discards credit; there is no refund.
- Prices: type 0 = 10, type 1 = 20, type 2 = 30, type 3 = 40 yuan.
- Cost = price × count, computed at 9 bits.
- **IDLE**
  - Display outputs hold the values from the last transaction.
  - `sel_vld` with type ≤ 3, count ≥ 1 and cost ≤ 255: latch `ticketType`, `ticketCount` and cost; clear `money` and `moneyReturn`; go to PAY.
  - Any other `sel_vld`: pulse `sel_err`; outputs unchanged.
  - `coin_vld` in IDLE: pulse `coin_reject`.
- **PAY**
  - On `coin_vld`: if `money` + value (9-bit sum) ≤ 255, `money` += value. Otherwise pulse `coin_reject` and leave `money` unchanged.
  - When the registered `money` ≥ cost, go to DISPENSE on the next edge.
  - `cancel` goes to REFUND. If `cancel` and `coin_vld` arrive together, cancel wins and the coin is rejected.
  - `sel_vld` in PAY is ignored; there is no `sel_err`.
- **DISPENSE**
  - `ticket_out` is high on alternate cycles, starting with the first DISPENSE cycle: `ticketCount` pulses in 2×`ticketCount`−1 cycles.
  - A down-counter tracks remaining tickets.
  - After the last pulse: `moneyReturn` = `money` − cost; go to CHANGE.
  - `cancel` and `coin_vld` are ignored here; coins get `coin_reject`.
- **REFUND**: `moneyReturn` = `money`; go to CHANGE.
- **CHANGE**: `change_vld` is high for one cycle; return to IDLE.

## Timing
- A coin strobe in cycle N is reflected in `money` at N+1.
- Payment completes in cycle M (`money` ≥ cost visible): the state is DISPENSE at M+1 and the first `ticket_out` is at M+1.
- Last ticket pulse in cycle P: `moneyReturn` updated and `change_vld` high at P+1; IDLE at P+2.
- Cancel in cycle C: `change_vld` high at C+2.
- `sel_vld` in cycle S: PAY and the new outputs are visible at S+1.

## Configuration
- `TICKET_TIMEOUT_EN` defined:
  - A 16-bit inactivity counter runs in PAY. It resets on entry to PAY and on each accepted coin.
  - Reaching `TIMEOUT_CYCLES` behaves exactly like `cancel` (PAY→REFUND), including with `money` = 0: `change_vld` is still asserted with `moneyReturn` = 0.
- Not defined: the counter logic is absent and PAY waits indefinitely.

## Structure
- Shared package `ticket_pkg`: price constants, coin-code values, state encoding (IDLE, PAY, DISPENSE, REFUND, CHANGE) and the `TIMEOUT_CYCLES` default.
- Sub-module `ticket_pulse_gen`: loaded with a count, it emits alternate-cycle pulses and a `done` strobe. It is instantiated in DISPENSE.

## Test plan
- Select type 1, count 3 (cost 60); three 20-yuan coins → `money` 60; three `ticket_out` pulses on alternate cycles; `change_vld` with `moneyReturn` 0.
- Select type 0, count 3 (cost 30); two 20-yuan coins → `money` 40; 3 tickets; `moneyReturn` 10.
- Select type 3, count 7 (cost 280) → `sel_err`; stays in IDLE. Select type 5, count 2 → `sel_err`.
- Select type 3, count 6 (cost 240); reach 239 with smaller coins; insert 20 → `coin_reject`, `money` stays 239; insert 1 → 240; 6 tickets; `moneyReturn` 0.
- Select type 2, count 1; insert 20 and 5; `cancel` in the same cycle as a 10-yuan coin → `coin_reject`; `moneyReturn` 25 with `change_vld`; zero `ticket_out` pulses.
- With `TICKET_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 50: select, insert 5, idle for 50 cycles → refund of 5. Separately, assert `rst` mid-DISPENSE → all outputs 0, IDLE on the next cycle.

Source files
------------

// File: rtl/ticket_pkg.sv
// Shared definitions for the ticket machine controller: sale state encoding,
// ticket prices, coin codes and the default inactivity timeout.
package ticket_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PAY      = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_REFUND   = 3'd3,
    ST_CHANGE   = 3'd4
  } state_e;

  localparam logic [7:0] PRICE_T0 = 8'd10;
  localparam logic [7:0] PRICE_T1 = 8'd20;
  localparam logic [7:0] PRICE_T2 = 8'd30;
  localparam logic [7:0] PRICE_T3 = 8'd40;

  localparam logic [1:0] COIN_1Y  = 2'd0;
  localparam logic [1:0] COIN_5Y  = 2'd1;
  localparam logic [1:0] COIN_10Y = 2'd2;
  localparam logic [1:0] COIN_20Y = 2'd3;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000;

  function automatic logic [7:0] price_of(input logic [1:0] ttype);
    logic [7:0] p;
    case (ttype)
      2'd0:    p = PRICE_T0;
      2'd1:    p = PRICE_T1;
      2'd2:    p = PRICE_T2;
      default: p = PRICE_T3;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] coin_value(input logic [1:0] code);
    logic [7:0] v;
    case (code)
      COIN_1Y:  v = 8'd1;
      COIN_5Y:  v = 8'd5;
      COIN_10Y: v = 8'd10;
      default:  v = 8'd20;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ticket_pulse_gen.sv
// Ticket pulse generator: loaded with a ticket count, emits one pulse every
// other cycle (first pulse in the cycle after the load) and flags the last one.
module ticket_pulse_gen (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] count_i,
  output logic       pulse_o,
  output logic       done_o
);

  logic       active_q, active_d;
  logic       phase_q, phase_d;
  logic [2:0] remain_q, remain_d;

  assign pulse_o = active_q & ~phase_q;
  assign done_o  = pulse_o & (remain_q == 3'd1);

  // next-state: remaining-ticket down-counter with terminal count at 1
  always_comb begin
    active_d = active_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    if (load_i) begin
      active_d = (count_i != 3'd0);
      phase_d  = 1'b0;
      remain_d = count_i;
    end else if (active_q) begin
      phase_d = ~phase_q;
      if (pulse_o) begin
        remain_d = remain_q - 3'd1;
        if (done_o) active_d = 1'b0;
      end
    end
  end

  // state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      phase_q  <= 1'b0;
      remain_q <= 3'd0;
    end else begin
      active_q <= active_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
    end
  end

endmodule

// File: rtl/ticket_vend_ctrl.sv
// Ticket machine sale controller: selection, payment, dispensing and change.
// Optional feature macro: TICKET_TIMEOUT_EN adds an inactivity auto-cancel in PAY.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for a selection; display outputs hold last sale
// PAY      | accumulating coins until money >= cost, or cancel
// DISPENSE | emitting ticket_out pulses on alternate cycles
// REFUND   | loading the full paid amount into moneyReturn
// CHANGE   | one-cycle change_vld strobe, then back to IDLE
module ticket_vend_ctrl
  import ticket_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sel_vld,
  input  logic [2:0] sel_type,
  input  logic [2:0] sel_count,
  input  logic       coin_vld,
  input  logic [1:0] coin_val,
  input  logic       cancel,
  output logic [7:0] money,
  output logic [2:0] ticketType,
  output logic [2:0] ticketCount,
  output logic [7:0] moneyReturn,
  output logic       ticket_out,
  output logic       change_vld,
  output logic       sel_err,
  output logic       coin_reject,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [7:0] money_q, money_d;
  logic [7:0] cost_q, cost_d;
  logic [7:0] ret_q, ret_d;
  logic [2:0] type_q, type_d;
  logic [2:0] count_q, count_d;
  logic       sel_err_q, sel_err_d;
  logic       coin_rej_q, coin_rej_d;
  logic       coin_accept;
  logic       pulse_load;
  logic       pulse;
  logic       pulse_done;
  logic       timeout;
  logic [8:0] sel_cost;
  logic [8:0] coin_sum;

  assign sel_cost = {1'b0, price_of(sel_type[1:0])} * {6'b0, sel_count};
  assign coin_sum = {1'b0, money_q} + {1'b0, coin_value(coin_val)};

`ifdef TICKET_TIMEOUT_EN
  localparam logic [15:0] TIMER_RELOAD = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] timer_q, timer_d;

  assign timeout = (state_q == ST_PAY) && (timer_q == 16'd0);

  // inactivity down-counter: reloaded on PAY entry and on every accepted coin
  always_comb begin
    timer_d = timer_q;
    if ((state_q == ST_IDLE && state_d == ST_PAY) || coin_accept) begin
      timer_d = TIMER_RELOAD;
    end else if (state_q == ST_PAY && timer_q != 16'd0) begin
      timer_d = timer_q - 16'd1;
    end
  end

  // inactivity counter register
  always_ff @(posedge clk) begin
    if (rst) timer_q <= 16'd0;
    else     timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  ticket_pulse_gen u_pulse_gen (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (pulse_load),
    .count_i (count_q),
    .pulse_o (pulse),
    .done_o  (pulse_done)
  );

  // next-state and datapath updates for the sale FSM
  always_comb begin
    state_d     = state_q;
    money_d     = money_q;
    cost_d      = cost_q;
    ret_d       = ret_q;
    type_d      = type_q;
    count_d     = count_q;
    sel_err_d   = 1'b0;
    coin_rej_d  = 1'b0;
    coin_accept = 1'b0;
    pulse_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        coin_rej_d = coin_vld;
        if (sel_vld) begin
          if (!sel_type[2] && sel_count != 3'd0 && !sel_cost[8]) begin
            type_d  = sel_type;
            count_d = sel_count;
            cost_d  = sel_cost[7:0];
            money_d = 8'd0;
            ret_d   = 8'd0;
            state_d = ST_PAY;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      ST_PAY: begin
        // cancel beats payment completion; a coin arriving with either is refused
        if (cancel || timeout) begin
          coin_rej_d = coin_vld;
          state_d    = ST_REFUND;
        end else if (money_q >= cost_q) begin
          coin_rej_d = coin_vld;
          pulse_load = 1'b1;
          state_d    = ST_DISPENSE;
        end else if (coin_vld) begin
          if (coin_sum[8]) begin
            coin_rej_d = 1'b1;
          end else begin
            money_d     = coin_sum[7:0];
            coin_accept = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        coin_rej_d = coin_vld;
        if (pulse_done) begin
          ret_d   = money_q - cost_q;
          state_d = ST_CHANGE;
        end
      end
      ST_REFUND: begin
        coin_rej_d = coin_vld;
        ret_d      = money_q;
        state_d    = ST_CHANGE;
      end
      ST_CHANGE: begin
        coin_rej_d = coin_vld;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      money_q    <= 8'd0;
      cost_q     <= 8'd0;
      ret_q      <= 8'd0;
      type_q     <= 3'd0;
      count_q    <= 3'd0;
      sel_err_q  <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      money_q    <= money_d;
      cost_q     <= cost_d;
      ret_q      <= ret_d;
      type_q     <= type_d;
      count_q    <= count_d;
      sel_err_q  <= sel_err_d;
      coin_rej_q <= coin_rej_d;
    end
  end

  assign money       = money_q;
  assign ticketType  = type_q;
  assign ticketCount = count_q;
  assign moneyReturn = ret_q;
  assign ticket_out  = pulse;
  assign change_vld  = (state_q == ST_CHANGE);
  assign sel_err     = sel_err_q;
  assign coin_reject = coin_rej_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ticket_vend_ctrl.sv
// Testbench for ticket_vend_ctrl: cycle-by-cycle vector table for two complete
// sales and the selection/coin rejection cases, then hand-written sequences
// for the overflow boundary, cancel, reset mid-dispense and the timeout.
module tb_ticket_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_vld;
  logic [2:0] sel_type;
  logic [2:0] sel_count;
  logic       coin_vld;
  logic [1:0] coin_val;
  logic       cancel;
  logic [7:0] money;
  logic [2:0] ticketType;
  logic [2:0] ticketCount;
  logic [7:0] moneyReturn;
  logic       ticket_out;
  logic       change_vld;
  logic       sel_err;
  logic       coin_reject;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ticket_vend_ctrl #(.TIMEOUT_CYCLES(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel_vld     (sel_vld),
    .sel_type    (sel_type),
    .sel_count   (sel_count),
    .coin_vld    (coin_vld),
    .coin_val    (coin_val),
    .cancel      (cancel),
    .money       (money),
    .ticketType  (ticketType),
    .ticketCount (ticketCount),
    .moneyReturn (moneyReturn),
    .ticket_out  (ticket_out),
    .change_vld  (change_vld),
    .sel_err     (sel_err),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  // flags field order: {ticket_out, change_vld, sel_err, coin_reject, busy}
  typedef struct packed {
    logic [7:0] money;
    logic [2:0] ttype;
    logic [2:0] tcnt;
    logic [7:0] ret;
    logic [4:0] flags;
  } outs_t;

  typedef struct {
    logic       sv;
    logic [2:0] st;
    logic [2:0] sc;
    logic       cv;
    logic [1:0] cval;
    logic       cn;
    outs_t      exp;
  } vec_t;

  vec_t vecs[$];

  function automatic outs_t outs();
    outs_t o;
    o = {money, ticketType, ticketCount, moneyReturn,
         ticket_out, change_vld, sel_err, coin_reject, busy};
    return o;
  endfunction

  task automatic add(input logic sv, input logic [2:0] st, input logic [2:0] sc,
                     input logic cv, input logic [1:0] cval, input logic cn,
                     input logic [7:0] m, input logic [2:0] t, input logic [2:0] c,
                     input logic [7:0] r, input logic [4:0] fl);
    vec_t v;
    v.sv = sv; v.st = st; v.sc = sc; v.cv = cv; v.cval = cval; v.cn = cn;
    v.exp = {m, t, c, r, fl};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // drive one cycle of inputs, then sample just after the rising edge
  task automatic step(input logic sv, input logic [2:0] st, input logic [2:0] sc,
                      input logic cv, input logic [1:0] cval, input logic cn);
    sel_vld = sv; sel_type = st; sel_count = sc;
    coin_vld = cv; coin_val = cval; cancel = cn;
    @(posedge clk);
    #1;
    sel_vld = 1'b0; sel_type = 3'd0; sel_count = 3'd0;
    coin_vld = 1'b0; coin_val = 2'd0; cancel = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic coin(input logic [1:0] c);
    step(1'b0, 3'd0, 3'd0, 1'b1, c, 1'b0);
  endtask

  task automatic sel(input logic [2:0] t, input logic [2:0] c);
    step(1'b1, t, c, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    int pulses;
    int n;
    bit seen;

    rst = 1'b1;
    sel_vld = 1'b0; sel_type = 3'd0; sel_count = 3'd0;
    coin_vld = 1'b0; coin_val = 2'd0; cancel = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;

    // sale 1: type 1 x3 (cost 60), three 20s, exact payment
    add(1, 1, 3, 0, 0, 0,  0, 1, 3,  0, 5'b00001);
    add(1, 2, 1, 0, 0, 0,  0, 1, 3,  0, 5'b00001);  // selection in PAY ignored
    add(0, 0, 0, 1, 3, 0, 20, 1, 3,  0, 5'b00001);
    add(0, 0, 0, 1, 3, 0, 40, 1, 3,  0, 5'b00001);
    add(0, 0, 0, 1, 3, 0, 60, 1, 3,  0, 5'b00001);
    add(0, 0, 0, 0, 0, 0, 60, 1, 3,  0, 5'b10001);  // first ticket
    add(0, 0, 0, 1, 0, 0, 60, 1, 3,  0, 5'b00011);  // coin refused in DISPENSE
    add(0, 0, 0, 0, 0, 1, 60, 1, 3,  0, 5'b10001);  // cancel ignored
    add(0, 0, 0, 0, 0, 0, 60, 1, 3,  0, 5'b00001);
    add(0, 0, 0, 0, 0, 0, 60, 1, 3,  0, 5'b10001);  // third ticket
    add(0, 0, 0, 0, 0, 0, 60, 1, 3,  0, 5'b01001);  // CHANGE
    add(0, 0, 0, 0, 0, 0, 60, 1, 3,  0, 5'b00000);  // IDLE, display held
    // sale 2: type 0 x3 (cost 30), two 20s, change 10
    add(1, 0, 3, 0, 0, 0,  0, 0, 3,  0, 5'b00001);
    add(0, 0, 0, 1, 3, 0, 20, 0, 3,  0, 5'b00001);
    add(0, 0, 0, 1, 3, 0, 40, 0, 3,  0, 5'b00001);
    add(0, 0, 0, 0, 0, 0, 40, 0, 3,  0, 5'b10001);
    add(0, 0, 0, 0, 0, 0, 40, 0, 3,  0, 5'b00001);
    add(0, 0, 0, 0, 0, 0, 40, 0, 3,  0, 5'b10001);
    add(0, 0, 0, 0, 0, 0, 40, 0, 3,  0, 5'b00001);
    add(0, 0, 0, 0, 0, 0, 40, 0, 3,  0, 5'b10001);
    add(0, 0, 0, 0, 0, 0, 40, 0, 3, 10, 5'b01001);
    add(0, 0, 0, 0, 0, 0, 40, 0, 3, 10, 5'b00000);
    // rejected selections and an IDLE coin
    add(1, 3, 7, 0, 0, 0, 40, 0, 3, 10, 5'b00100);  // cost 280
    add(1, 5, 2, 0, 0, 0, 40, 0, 3, 10, 5'b00100);  // bad type
    add(1, 1, 0, 0, 0, 0, 40, 0, 3, 10, 5'b00100);  // zero count
    add(0, 0, 0, 1, 2, 0, 40, 0, 3, 10, 5'b00010);  // coin in IDLE
    add(0, 0, 0, 0, 0, 0, 40, 0, 3, 10, 5'b00000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].sv, vecs[i].st, vecs[i].sc, vecs[i].cv, vecs[i].cval, vecs[i].cn);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // type 3 x6 (cost 240): reach 239, 20 overflows, 1 completes
    sel(3'd3, 3'd6);
    chk("ovf_sel_type", 32'(ticketType), 32'd3);
    chk("ovf_sel_count", 32'(ticketCount), 32'd6);
    for (int i = 0; i < 11; i++) coin(2'd3);
    coin(2'd2);
    coin(2'd1);
    for (int i = 0; i < 4; i++) coin(2'd0);
    chk("ovf_money_239", 32'(money), 32'd239);
    coin(2'd3);
    chk("ovf_reject", 32'(coin_reject), 32'd1);
    chk("ovf_money_held", 32'(money), 32'd239);
    coin(2'd0);
    chk("ovf_money_240", 32'(money), 32'd240);
    pulses = 0; n = 0; seen = 0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      idle();
      if (ticket_out) pulses++;
      if (change_vld) begin seen = 1; n = i; end
    end
    chk("ovf_change_seen", 32'(seen), 32'd1);
    chk("ovf_pulses", 32'(pulses), 32'd6);
    chk("ovf_change_cycle", 32'(n), 32'd12);
    chk("ovf_return", 32'(moneyReturn), 32'd0);
    idle();
    chk("ovf_idle", 32'(busy), 32'd0);

    // cancel with a simultaneous coin after paying 25 toward 30
    sel(3'd2, 3'd1);
    pulses = 0;
    coin(2'd3); if (ticket_out) pulses++;
    coin(2'd1); if (ticket_out) pulses++;
    chk("cxl_money", 32'(money), 32'd25);
    step(1'b0, 3'd0, 3'd0, 1'b1, 2'd2, 1'b1);
    if (ticket_out) pulses++;
    chk("cxl_coin_reject", 32'(coin_reject), 32'd1);
    chk("cxl_money_held", 32'(money), 32'd25);
    chk("cxl_no_change_yet", 32'(change_vld), 32'd0);
    idle();
    if (ticket_out) pulses++;
    chk("cxl_change_vld", 32'(change_vld), 32'd1);
    chk("cxl_return", 32'(moneyReturn), 32'd25);
    idle();
    if (ticket_out) pulses++;
    chk("cxl_idle", 32'(busy), 32'd0);
    chk("cxl_no_tickets", 32'(pulses), 32'd0);

    // reset in the middle of dispensing
    sel(3'd0, 3'd2);
    coin(2'd3);
    idle();
    chk("rst_in_dispense", 32'(ticket_out), 32'd1);
    rst = 1'b1;
    idle();
    chk("rst_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    idle();
    chk("rst_stays_idle", 32'(outs()), 32'd0);

`ifdef TICKET_TIMEOUT_EN
    // 5 paid toward 10, then no activity: auto-refund after 50 idle cycles
    sel(3'd0, 3'd1);
    coin(2'd1);
    seen = 0; n = 0;
    for (int i = 1; i <= 80 && !seen; i++) begin
      idle();
      if (change_vld) begin seen = 1; n = i; end
    end
    chk("tmo_change_seen", 32'(seen), 32'd1);
    chk("tmo_change_cycle", 32'(n), 32'd51);
    chk("tmo_return", 32'(moneyReturn), 32'd5);
    idle();
    chk("tmo_idle", 32'(busy), 32'd0);
`else
    // without the timeout, PAY waits indefinitely
    sel(3'd0, 3'd1);
    coin(2'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      idle();
      if (change_vld || !busy) seen = 1;
    end
    chk("notmo_still_paying", 32'(seen), 32'd0);
    step(1'b0, 3'd0, 3'd0, 1'b0, 2'd0, 1'b1);
    idle();
    chk("notmo_refund", 32'(moneyReturn), 32'd5);
    idle();
    chk("notmo_idle", 32'(busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
